// File: rtl/rll_pkg.sv
// RLL(2,7) shared definitions: codeword table, lengths and FSM states.
// Used by rll27_decoder and its NRZI demodulator.
package rll_pkg;

  typedef enum logic {HUNT, DECODE} rll_dec_state_e;

  localparam logic [3:0] RLL_D  = 4'd2;
  localparam logic [3:0] RLL_K  = 4'd7;
  localparam logic [3:0] CW_MAX = 4'd8;

  localparam logic [7:0] CW_11   = 8'b0000_1000;
  localparam logic [7:0] CW_10   = 8'b0000_0100;
  localparam logic [7:0] CW_011  = 8'b0000_1000;
  localparam logic [7:0] CW_010  = 8'b0010_0100;
  localparam logic [7:0] CW_000  = 8'b0000_0100;
  localparam logic [7:0] CW_0011 = 8'b0000_1000;
  localparam logic [7:0] CW_0010 = 8'b0010_0100;

  localparam logic [3:0] CL_2 = 4'd4;
  localparam logic [3:0] CL_3 = 4'd6;
  localparam logic [3:0] CL_4 = 4'd8;

  localparam logic [3:0] D_11   = 4'b0011;
  localparam logic [3:0] D_10   = 4'b0010;
  localparam logic [3:0] D_011  = 4'b0011;
  localparam logic [3:0] D_010  = 4'b0010;
  localparam logic [3:0] D_000  = 4'b0000;
  localparam logic [3:0] D_0011 = 4'b0011;
  localparam logic [3:0] D_0010 = 4'b0010;

  localparam logic [2:0] DL_2 = 3'd2;
  localparam logic [2:0] DL_3 = 3'd3;
  localparam logic [2:0] DL_4 = 3'd4;

  typedef struct packed {
    logic       hit;
    logic [3:0] data;
    logic [2:0] len;
  } rll_dec_t;

  // w holds exactly n code bits, right-aligned, upper bits zero
  function automatic rll_dec_t rll_lookup(
    input logic [7:0] w,
    input logic [3:0] n
  );
    rll_dec_t r;
    r = '0;
    unique case (1'b1)
      (n == CL_2 && w == CW_11):   r = {1'b1, D_11, DL_2};
      (n == CL_2 && w == CW_10):   r = {1'b1, D_10, DL_2};
      (n == CL_3 && w == CW_011):  r = {1'b1, D_011, DL_3};
      (n == CL_3 && w == CW_010):  r = {1'b1, D_010, DL_3};
      (n == CL_3 && w == CW_000):  r = {1'b1, D_000, DL_3};
      (n == CL_4 && w == CW_0011): r = {1'b1, D_0011, DL_4};
      (n == CL_4 && w == CW_0010): r = {1'b1, D_0010, DL_4};
      default:                     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rll_nrzi_demod.sv
// NRZI demodulator: a code bit is 1 whenever the line level changes.
module rll_nrzi_demod #(
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic data_i,
  output logic c_o
);

  logic r_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_prev <= INIT_LEVEL;
    else         r_prev <= data_i;
  end

  assign c_o = data_i ^ r_prev;

endmodule

// File: rtl/rll27_decoder.sv
// RLL(2,7) decoder: NRZI demod, greedy codeword parse, parallel output.
// Optional run-length monitor: RLL_DECODER_RUNLENGTH_CHECK_EN.
module rll27_decoder
  import rll_pkg::*;
#(
  parameter logic INIT_LEVEL = 1'b0,
  parameter logic AUTO_SYNC  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  input  logic       sync_i,
  output logic [3:0] dec_data_o,
  output logic [2:0] dec_len_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       rl_err_o
);

  rll_dec_state_e r_state, w_state_n;
  logic [6:0] r_code, w_code_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic [3:0] r_data, w_data_n;
  logic [2:0] r_len, w_len_n;
  logic       r_valid, w_valid_n;
  logic       r_err, w_err_n;
  logic       w_c;
  logic [3:0] w_cnt_inc;
  rll_dec_t   w_dec;

  rll_nrzi_demod #(
    .INIT_LEVEL(INIT_LEVEL)
  ) u_demod (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .data_i(data_i),
    .c_o   (w_c)
  );

  assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;
  assign w_dec     = rll_lookup({r_code, w_c}, w_cnt_inc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= AUTO_SYNC ? DECODE : HUNT;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      HUNT:    if (sync_i) w_state_n = DECODE;
      DECODE:  w_state_n = DECODE;
      default: w_state_n = HUNT;
    endcase
  end

  // sync always restarts alignment, even on a completing bit
  always_comb begin
    w_code_n  = r_code;
    w_cnt_n   = r_cnt;
    w_data_n  = r_data;
    w_len_n   = r_len;
    w_valid_n = 1'b0;
    w_err_n   = 1'b0;
    if (sync_i) begin
      w_code_n = {6'b0, w_c};
      w_cnt_n  = 3'd1;
    end else if (r_state == DECODE) begin
      if (w_dec.hit) begin
        w_code_n  = '0;
        w_cnt_n   = '0;
        w_data_n  = w_dec.data;
        w_len_n   = w_dec.len;
        w_valid_n = 1'b1;
      end else if (w_cnt_inc == CW_MAX) begin
        w_code_n = '0;
        w_cnt_n  = '0;
        w_err_n  = 1'b1;
      end else begin
        w_code_n = {r_code[5:0], w_c};
        w_cnt_n  = w_cnt_inc[2:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_code  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_code  <= w_code_n;
      r_cnt   <= w_cnt_n;
      r_data  <= w_data_n;
      r_len   <= w_len_n;
      r_valid <= w_valid_n;
      r_err   <= w_err_n;
    end
  end

  assign dec_data_o = r_data;
  assign dec_len_o  = r_len;
  assign valid_o    = r_valid;
  assign err_o      = r_err;

`ifdef RLL_DECODER_RUNLENGTH_CHECK_EN
  logic [3:0] r_zrun;
  logic       r_seen1;
  logic       r_rl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_zrun  <= '0;
      r_seen1 <= 1'b0;
      r_rl    <= 1'b0;
    end else if (sync_i) begin
      r_zrun  <= w_c ? 4'd0 : 4'd1;
      r_seen1 <= w_c;
      r_rl    <= 1'b0;
    end else if (r_state == DECODE) begin
      if (w_c) begin
        r_rl    <= r_seen1 && (r_zrun < RLL_D);
        r_zrun  <= '0;
        r_seen1 <= 1'b1;
      end else begin
        r_rl   <= (r_zrun == RLL_K);
        r_zrun <= (r_zrun == CW_MAX) ? r_zrun : r_zrun + 4'd1;
      end
    end else begin
      r_rl <= 1'b0;
    end
  end

  assign rl_err_o = r_rl;
`else
  assign rl_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rll27_decoder.sv
// Self-checking bench for rll27_decoder against a table-driven model.
// Run-length checks are active when RLL_DECODER_RUNLENGTH_CHECK_EN is set.
module tb_rll27_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] dec_data;
  logic [2:0] dec_len;
  logic       valid;
  logic       err;
  logic       rl_err;

  int checks = 0;
  int errors = 0;

  rll27_decoder dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .data_i    (data),
    .sync_i    (sync),
    .dec_data_o(dec_data),
    .dec_len_o (dec_len),
    .valid_o   (valid),
    .err_o     (err),
    .rl_err_o  (rl_err)
  );

  always #5 clk = ~clk;

  // codeword table: code value, code length, data value, data length
  int code_v [7] = '{8, 4, 8, 36, 4, 8, 36};
  int code_n [7] = '{4, 4, 6, 6, 6, 8, 8};
  int dat_v  [7] = '{3, 2, 3, 2, 0, 3, 2};
  int dat_n  [7] = '{2, 2, 3, 3, 3, 4, 4};

  bit level;
  bit in_sync;
  int cur_v, cur_n;
  int exp_data, exp_len;
  bit exp_valid, exp_err, exp_rl;
  int zeros;
  bit seen1;

  int obs_d[$];
  int obs_l[$];
  int err_seen;

  task automatic model_reset();
    level    = 1'b0;
    in_sync  = 1'b0;
    cur_v    = 0;
    cur_n    = 0;
    exp_data = 0;
    exp_len  = 0;
    zeros    = 0;
    seen1    = 1'b0;
  endtask

  task automatic model(input bit c, input bit s);
    bit hit;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_rl    = 1'b0;
    if (s) begin
      in_sync = 1'b1;
      cur_v = c;
      cur_n = 1;
`ifdef RLL_DECODER_RUNLENGTH_CHECK_EN
      zeros = c ? 0 : 1;
      seen1 = c;
`endif
    end else if (in_sync) begin
      cur_v = cur_v * 2 + c;
      cur_n = cur_n + 1;
      hit = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (!hit && cur_n == code_n[i] && cur_v == code_v[i]) begin
          hit = 1'b1;
          exp_valid = 1'b1;
          exp_data = dat_v[i];
          exp_len = dat_n[i];
        end
      end
      if (hit) begin
        cur_v = 0;
        cur_n = 0;
      end else if (cur_n == 8) begin
        exp_err = 1'b1;
        cur_v = 0;
        cur_n = 0;
      end
`ifdef RLL_DECODER_RUNLENGTH_CHECK_EN
      if (c) begin
        exp_rl = seen1 && zeros < 2;
        zeros = 0;
        seen1 = 1'b1;
      end else begin
        zeros = zeros + 1;
        exp_rl = (zeros == 8);
      end
`endif
    end
  endtask

  task automatic step(input bit c, input bit s);
    level = level ^ c;
    data = level;
    sync = s;
    @(posedge clk);
    #1;
    model(c, s);
    checks++;
    if (valid !== exp_valid) begin
      errors++;
      $display("FAIL valid: got %b want %b at %0t", valid, exp_valid, $time);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err: got %b want %b at %0t", err, exp_err, $time);
    end
    checks++;
    if (dec_data !== exp_data[3:0]) begin
      errors++;
      $display("FAIL data: got %h want %h at %0t", dec_data, exp_data, $time);
    end
    checks++;
    if (dec_len !== exp_len[2:0]) begin
      errors++;
      $display("FAIL len: got %0d want %0d at %0t", dec_len, exp_len, $time);
    end
    checks++;
    if (rl_err !== exp_rl) begin
      errors++;
      $display("FAIL rl_err: got %b want %b at %0t", rl_err, exp_rl, $time);
    end
    if (valid === 1'b1) begin
      obs_d.push_back(int'(dec_data));
      obs_l.push_back(int'(dec_len));
    end
    if (err === 1'b1) err_seen++;
  endtask

  task automatic send_code(input int idx, input bit s);
    for (int i = code_n[idx] - 1; i >= 0; i--)
      step(bit'((code_v[idx] >> i) & 1), s && (i == code_n[idx] - 1));
  endtask

  task automatic clear_log();
    obs_d.delete();
    obs_l.delete();
    err_seen = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({dec_data, dec_len, valid, err, rl_err} !== 10'd0) begin
      errors++;
      $display("FAIL %s: got d=%h l=%0d v=%b e=%b rl=%b want all 0",
               tag, dec_data, dec_len, valid, err, rl_err);
    end
  endtask

  task automatic check_strobe(input string tag, input int k, input int d,
                              input int l);
    checks++;
    if (obs_d.size() <= k) begin
      errors++;
      $display("FAIL %s: strobe %0d missing, want (%0d,%0d)", tag, k, d, l);
    end else if (obs_d[k] != d || obs_l[k] != l) begin
      errors++;
      $display("FAIL %s: strobe %0d got (%0d,%0d) want (%0d,%0d)",
               tag, k, obs_d[k], obs_l[k], d, l);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_log();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_count("hunt_silent", obs_d.size() + err_seen, 0);
    send_code(0, 1'b1);
    checks++;
    if (valid !== 1'b1 || dec_data !== 4'b0011 || dec_len !== 3'd2) begin
      errors++;
      $display("FAIL basic: got v=%b d=%b l=%0d want v=1 d=0011 l=2",
               valid, dec_data, dec_len);
    end
  endtask

  task automatic test_stream();
    clear_log();
    send_code(1, 1'b0);
    send_code(2, 1'b0);
    send_code(6, 1'b0);
    check_count("stream_n", obs_d.size(), 3);
    check_strobe("stream", 0, 2, 2);
    check_strobe("stream", 1, 3, 3);
    check_strobe("stream", 2, 2, 4);
    check_count("stream_err", err_seen, 0);
  endtask

  task automatic test_error();
    clear_log();
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    check_count("err_pulse", err_seen, 1);
    check_count("err_novalid", obs_d.size(), 0);
    send_code(1, 1'b0);
    check_count("after_err_n", obs_d.size(), 1);
    check_strobe("after_err", 0, 2, 2);
  endtask

  task automatic test_resync();
    clear_log();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    send_code(2, 1'b1);
    check_count("resync_n", obs_d.size(), 1);
    check_strobe("resync", 0, 3, 3);
    check_count("resync_err", err_seen, 0);
  endtask

  task automatic test_async_reset();
    send_code(0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_log();
    send_code(0, 1'b1);
    check_count("post_reset_n", obs_d.size(), 1);
    check_strobe("post_reset", 0, 3, 2);
  endtask

  task automatic test_random();
    int r, n;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r < 2) begin
        n = $urandom_range(1, 9);
        for (int b = 0; b < n; b++)
          step(bit'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      end else begin
        send_code(int'($urandom % 7), $urandom_range(0, 4) == 0);
      end
    end
  endtask

  task automatic test_runlength();
    send_code(0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
`ifdef RLL_DECODER_RUNLENGTH_CHECK_EN
    checks++;
    if (rl_err !== 1'b1) begin
      errors++;
      $display("FAIL rl_short: got %b want 1", rl_err);
    end
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
`ifdef RLL_DECODER_RUNLENGTH_CHECK_EN
    checks++;
    if (rl_err !== 1'b1) begin
      errors++;
      $display("FAIL rl_long: got %b want 1", rl_err);
    end
`endif
    step(1'b0, 1'b0);
    send_code(3, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_error();
    test_resync();
    test_async_reset();
    test_runlength();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
